controller_pipe: RTL and testbench
==================================

CONTROLLER_PIPE -- requirements
Module: controller_pipe

Interface
REQ-001 SHALL have parameter FBITS, default 6: opcode width.
REQ-002 SHALL have parameter INSBITS, default 6: funct width.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port i_clk, input, 1 bit: clock, rising edge.
REQ-005 SHALL have port i_reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port opcode, input, FBITS bits: instruction[31:26].
REQ-007 SHALL have port i_funct, input, INSBITS bits: instruction[5:0].
REQ-008 SHALL have 1-bit outputs Reg_write, ALU_source (1 = immediate), Mem_write, Mem_read, Mem_to_Reg, BEQ_flag, BNE_flag, Jump_flag and Link_flag (1 = write PC+8).
REQ-009 SHALL have output ALU_op, 3 bits: 000 add, 001 sub, 010 R-type (ALU decodes funct), 011 and, 100 or, 101 xor, 110 lui, 111 slt.
REQ-010 SHALL have output Reg_dst, 2 bits: 00 rt, 01 rd, 10 r31.
REQ-011 SHALL have output Select_Addr, 2 bits: 00 PC+4, 01 jump target, 10 rs register.
REQ-012 SHALL have output Size_control, 5 bits: [0] byte, [1] half, [2] word, [3] zero-extend load, [4] store.

Function
REQ-013 SHALL decode combinationally and register all outputs on the rising edge of i_clk, giving 1-cycle latency.
REQ-014 SHALL default every unlisted control field to 0.
REQ-015 For R-type (opcode 000000) with funct other than 001000 or 001001, SHALL set Reg_write=1, Reg_dst=01 and ALU_op=010.
REQ-016 For JR (funct 001000), SHALL set Jump_flag=1 and Select_Addr=10, with Reg_write=0.
REQ-017 For JALR (funct 001001), SHALL set Jump_flag=1, Select_Addr=10, Reg_write=1, Reg_dst=01 and Link_flag=1.
REQ-018 For ADDI 001000, ANDI 001100, ORI 001101, XORI 001110, SLTI 001010 and LUI 001111, SHALL set Reg_write=1, ALU_source=1 and Reg_dst=00, with ALU_op 000, 011, 100, 101, 111 and 110 respectively.
REQ-019 For BEQ 000100 and BNE 000101, SHALL set ALU_op=001 and set BEQ_flag or BNE_flag respectively.
REQ-020 For J 000010, SHALL set Jump_flag=1 and Select_Addr=01.
REQ-021 For JAL 000011, SHALL additionally set Reg_write=1, Reg_dst=10 and Link_flag=1.
REQ-022 For loads (LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101, LWU 100111), SHALL set Reg_write=1, ALU_source=1, Mem_read=1, Mem_to_Reg=1, ALU_op=000 and Reg_dst=00.
REQ-023 For loads, Size_control SHALL be: LB 00001, LH 00010, LW 00100, LBU 01001, LHU 01010, LWU 01100.
REQ-024 For stores (SB 101000, SH 101001, SW 101011), SHALL set ALU_source=1, Mem_write=1 and ALU_op=000, with Size_control 10001, 10010 and 10100 respectively.
REQ-025 For any unrecognised opcode, SHALL drive all outputs 0 (NOP).
REQ-026 SHALL never assert Mem_read and Mem_write together.
REQ-027 SHALL assert at most one of BEQ_flag, BNE_flag and Jump_flag.

Reset
REQ-028 While i_reset_n=0, SHALL clear all outputs to 0 immediately, independent of i_clk.
REQ-029 SHALL resume decoding on the first rising edge of i_clk after reset release.

Configuration
REQ-030 With macro CONTROLLER_PIPE_FLUSH_EN defined, SHALL add input i_flush (1 bit); i_flush=1 at a clock edge SHALL load all-zero outputs (bubble) and take priority over decode.
REQ-031 Without CONTROLLER_PIPE_FLUSH_EN, SHALL have no i_flush port and register decode unconditionally.

Structure
REQ-032 Opcode/funct constants and the ALU_op, Reg_dst, Select_Addr and Size_control encodings SHALL live in shared package controller_pipe_pkg.
REQ-033 Combinational decode SHALL be sub-module controller_pipe_decode; controller_pipe SHALL contain only the output register and flush logic.

Verification
REQ-034 opcode=000000, funct=100000 -> next cycle: Reg_write=1, Reg_dst=01, ALU_op=010, all other outputs 0.
REQ-035 opcode=000000, funct=001001 -> Jump_flag=1, Select_Addr=10, Link_flag=1, Reg_write=1, Reg_dst=01.
REQ-036 opcode=000011 -> Jump_flag=1, Select_Addr=01, Reg_dst=10, Link_flag=1, Reg_write=1.
REQ-037 opcode=100101 -> Mem_read=1, Mem_to_Reg=1, Size_control=01010, ALU_source=1; then opcode=101001 -> Mem_write=1, Size_control=10010, Reg_write=0.
REQ-038 opcode=000101 -> BNE_flag=1, ALU_op=001, BEQ_flag=0; opcode=111111 -> all outputs 0.
REQ-039 Drive i_reset_n=0 mid-stream with opcode=100011 applied -> all outputs 0 immediately; after release, the next edge yields the LW decode.

Source files
------------

// File: rtl/controller_pipe_pkg.sv
// controller_pipe_pkg: shared opcode/funct constants, control-field encodings
// and the bundled control word passed from the decoder to the output register.
// No ports.

package controller_pipe_pkg;

    // Opcodes, instruction[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_LWU   = 6'b100111;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Funct codes, instruction[5:0], that change R-type behaviour
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_JALR  = 6'b001001;

    typedef enum logic [2:0] {
        AluAdd   = 3'b000,
        AluSub   = 3'b001,
        AluRtype = 3'b010,
        AluAnd   = 3'b011,
        AluOr    = 3'b100,
        AluXor   = 3'b101,
        AluLui   = 3'b110,
        AluSlt   = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        DstRt  = 2'b00,
        DstRd  = 2'b01,
        DstR31 = 2'b10
    } reg_dst_e;

    typedef enum logic [1:0] {
        SelPc4    = 2'b00,
        SelJump   = 2'b01,
        SelRs     = 2'b10
    } sel_addr_e;

    // Size_control: [0] byte, [1] half, [2] word, [3] zero-extend, [4] store
    localparam logic [4:0] SZ_LB  = 5'b00001;
    localparam logic [4:0] SZ_LH  = 5'b00010;
    localparam logic [4:0] SZ_LW  = 5'b00100;
    localparam logic [4:0] SZ_LBU = 5'b01001;
    localparam logic [4:0] SZ_LHU = 5'b01010;
    localparam logic [4:0] SZ_LWU = 5'b01100;
    localparam logic [4:0] SZ_SB  = 5'b10001;
    localparam logic [4:0] SZ_SH  = 5'b10010;
    localparam logic [4:0] SZ_SW  = 5'b10100;

    typedef struct packed {
        logic      reg_write;
        logic      alu_source;
        logic      mem_write;
        logic      mem_read;
        logic      mem_to_reg;
        logic      beq_flag;
        logic      bne_flag;
        logic      jump_flag;
        logic      link_flag;
        alu_op_e   alu_op;
        reg_dst_e  reg_dst;
        sel_addr_e select_addr;
        logic [4:0] size_control;
    } ctrl_t;

endpackage

// File: rtl/controller_pipe_decode.sv
// controller_pipe_decode: purely combinational main-control decode.
// Ports:
//   opcode  - instruction[31:26]
//   i_funct - instruction[5:0], only consulted for R-type
//   ctrl    - decoded control word; all-zero (NOP) for unrecognised opcodes

module controller_pipe_decode
    import controller_pipe_pkg::*;
#(
    parameter int unsigned FBITS   = 6,
    parameter int unsigned INSBITS = 6
) (
    input  logic [FBITS-1:0]   opcode,
    input  logic [INSBITS-1:0] i_funct,
    output ctrl_t              ctrl
);

    // Encodings are 6 bits wide regardless of how the ports are parameterised
    logic [5:0] op;
    logic [5:0] fn;

    assign op = 6'(opcode);
    assign fn = 6'(i_funct);

    // Shared setup for immediate ALU ops and loads: write rt from ALU/imm
    function automatic ctrl_t imm_write(input alu_op_e alu);
        ctrl_t c;
        c            = '0;
        c.reg_write  = 1'b1;
        c.alu_source = 1'b1;
        c.reg_dst    = DstRt;
        c.alu_op     = alu;
        return c;
    endfunction

    function automatic ctrl_t load(input logic [4:0] size);
        ctrl_t c;
        c              = imm_write(AluAdd);
        c.mem_read     = 1'b1;
        c.mem_to_reg   = 1'b1;
        c.size_control = size;
        return c;
    endfunction

    function automatic ctrl_t store(input logic [4:0] size);
        ctrl_t c;
        c              = '0;
        c.alu_source   = 1'b1;
        c.mem_write    = 1'b1;
        c.alu_op       = AluAdd;
        c.size_control = size;
        return c;
    endfunction

    always_comb begin
        ctrl = '0;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_JR: begin
                        ctrl.jump_flag   = 1'b1;
                        ctrl.select_addr = SelRs;
                    end
                    FN_JALR: begin
                        ctrl.jump_flag   = 1'b1;
                        ctrl.select_addr = SelRs;
                        ctrl.reg_write   = 1'b1;
                        ctrl.reg_dst     = DstRd;
                        ctrl.link_flag   = 1'b1;
                    end
                    default: begin
                        ctrl.reg_write = 1'b1;
                        ctrl.reg_dst   = DstRd;
                        ctrl.alu_op    = AluRtype;
                    end
                endcase
            end
            OP_ADDI: ctrl = imm_write(AluAdd);
            OP_ANDI: ctrl = imm_write(AluAnd);
            OP_ORI:  ctrl = imm_write(AluOr);
            OP_XORI: ctrl = imm_write(AluXor);
            OP_SLTI: ctrl = imm_write(AluSlt);
            OP_LUI:  ctrl = imm_write(AluLui);
            OP_BEQ: begin
                ctrl.alu_op   = AluSub;
                ctrl.beq_flag = 1'b1;
            end
            OP_BNE: begin
                ctrl.alu_op   = AluSub;
                ctrl.bne_flag = 1'b1;
            end
            OP_J: begin
                ctrl.jump_flag   = 1'b1;
                ctrl.select_addr = SelJump;
            end
            OP_JAL: begin
                ctrl.jump_flag   = 1'b1;
                ctrl.select_addr = SelJump;
                ctrl.reg_write   = 1'b1;
                ctrl.reg_dst     = DstR31;
                ctrl.link_flag   = 1'b1;
            end
            OP_LB:  ctrl = load(SZ_LB);
            OP_LH:  ctrl = load(SZ_LH);
            OP_LW:  ctrl = load(SZ_LW);
            OP_LBU: ctrl = load(SZ_LBU);
            OP_LHU: ctrl = load(SZ_LHU);
            OP_LWU: ctrl = load(SZ_LWU);
            OP_SB:  ctrl = store(SZ_SB);
            OP_SH:  ctrl = store(SZ_SH);
            OP_SW:  ctrl = store(SZ_SW);
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/controller_pipe.sv
// controller_pipe: pipelined main controller. Decodes opcode/funct and
// registers every control output, so outputs follow inputs by one cycle.
// Optional macro CONTROLLER_PIPE_FLUSH_EN adds i_flush, which loads an
// all-zero bubble at the clock edge in preference to the decode.
// Ports:
//   i_clk, i_reset_n      - clock (rising edge), async active-low reset
//   i_flush               - bubble request (only with CONTROLLER_PIPE_FLUSH_EN)
//   opcode, i_funct       - instruction[31:26] and instruction[5:0]
//   Reg_write .. Link_flag, ALU_op, Reg_dst, Select_Addr, Size_control
//                         - registered control outputs

module controller_pipe
    import controller_pipe_pkg::*;
#(
    parameter int unsigned FBITS   = 6,
    parameter int unsigned INSBITS = 6
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
`ifdef CONTROLLER_PIPE_FLUSH_EN
    input  logic               i_flush,
`endif
    input  logic [FBITS-1:0]   opcode,
    input  logic [INSBITS-1:0] i_funct,
    output logic               Reg_write,
    output logic               ALU_source,
    output logic               Mem_write,
    output logic               Mem_read,
    output logic               Mem_to_Reg,
    output logic               BEQ_flag,
    output logic               BNE_flag,
    output logic               Jump_flag,
    output logic               Link_flag,
    output logic [2:0]         ALU_op,
    output logic [1:0]         Reg_dst,
    output logic [1:0]         Select_Addr,
    output logic [4:0]         Size_control
);

    ctrl_t dec_ctrl;
    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    controller_pipe_decode #(
        .FBITS   (FBITS),
        .INSBITS (INSBITS)
    ) u_decode (
        .opcode  (opcode),
        .i_funct (i_funct),
        .ctrl    (dec_ctrl)
    );

`ifdef CONTROLLER_PIPE_FLUSH_EN
    always_comb begin
        ctrl_d = dec_ctrl;
        if (i_flush) begin
            ctrl_d = '0;
        end
    end
`else
    always_comb begin
        ctrl_d = dec_ctrl;
    end
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign Reg_write    = ctrl_q.reg_write;
    assign ALU_source   = ctrl_q.alu_source;
    assign Mem_write    = ctrl_q.mem_write;
    assign Mem_read     = ctrl_q.mem_read;
    assign Mem_to_Reg   = ctrl_q.mem_to_reg;
    assign BEQ_flag     = ctrl_q.beq_flag;
    assign BNE_flag     = ctrl_q.bne_flag;
    assign Jump_flag    = ctrl_q.jump_flag;
    assign Link_flag    = ctrl_q.link_flag;
    assign ALU_op       = ctrl_q.alu_op;
    assign Reg_dst      = ctrl_q.reg_dst;
    assign Select_Addr  = ctrl_q.select_addr;
    assign Size_control = ctrl_q.size_control;

endmodule

// File: tb/tb_controller_pipe.sv
// tb_controller_pipe: directed self-checking bench for controller_pipe.
// Expected control words are written out by hand per instruction.

module tb_controller_pipe;

    logic       i_clk;
    logic       i_reset_n;
    logic [5:0] opcode;
    logic [5:0] i_funct;
`ifdef CONTROLLER_PIPE_FLUSH_EN
    logic       i_flush;
`endif
    logic       Reg_write, ALU_source, Mem_write, Mem_read, Mem_to_Reg;
    logic       BEQ_flag, BNE_flag, Jump_flag, Link_flag;
    logic [2:0] ALU_op;
    logic [1:0] Reg_dst, Select_Addr;
    logic [4:0] Size_control;

    int n_cmp = 0;
    int n_bad = 0;

    controller_pipe dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
`ifdef CONTROLLER_PIPE_FLUSH_EN
        .i_flush      (i_flush),
`endif
        .opcode       (opcode),
        .i_funct      (i_funct),
        .Reg_write    (Reg_write),
        .ALU_source   (ALU_source),
        .Mem_write    (Mem_write),
        .Mem_read     (Mem_read),
        .Mem_to_Reg   (Mem_to_Reg),
        .BEQ_flag     (BEQ_flag),
        .BNE_flag     (BNE_flag),
        .Jump_flag    (Jump_flag),
        .Link_flag    (Link_flag),
        .ALU_op       (ALU_op),
        .Reg_dst      (Reg_dst),
        .Select_Addr  (Select_Addr),
        .Size_control (Size_control)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Observed word layout:
    // {RW, AS, MW, MR, M2R, BEQ, BNE, J, L, ALU_op[2:0], Reg_dst[1:0], Sel[1:0], Size[4:0]}
    logic [20:0] obs;
    assign obs = {Reg_write, ALU_source, Mem_write, Mem_read, Mem_to_Reg,
                  BEQ_flag, BNE_flag, Jump_flag, Link_flag,
                  ALU_op, Reg_dst, Select_Addr, Size_control};

    // Hand-written expected words (flags as a 9-bit group, then fields)
    function automatic logic [20:0] w(input logic [8:0] flags, input logic [2:0] alu,
                                      input logic [1:0] dst, input logic [1:0] sel,
                                      input logic [4:0] size);
        return {flags, alu, dst, sel, size};
    endfunction

    task automatic check(input string tag, input logic [20:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Apply an instruction, let one rising edge pass, sample 1 ns later
    task automatic step(input logic [5:0] op, input logic [5:0] fn);
        opcode  = op;
        i_funct = fn;
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_reset_n = 1'b0;
        opcode    = 6'b100011;
        i_funct   = 6'b000000;
`ifdef CONTROLLER_PIPE_FLUSH_EN
        i_flush   = 1'b0;
`endif
        #12;
        check("reset", '0);
        i_reset_n = 1'b1;

        //                 flags: RW AS MW MR M2R BEQ BNE J L
        step(6'b000000, 6'b100000);
        check("r_add",  w(9'b1_0_0_0_0_0_0_0_0, 3'b010, 2'b01, 2'b00, 5'b00000));
        // Output must hold until the next edge
        opcode = 6'b111111;
        #1;
        check("latency_hold", w(9'b1_0_0_0_0_0_0_0_0, 3'b010, 2'b01, 2'b00, 5'b00000));
        step(6'b111111, 6'b000000);
        check("nop_3f", '0);
        step(6'b000000, 6'b100010);
        check("r_sub",  w(9'b1_0_0_0_0_0_0_0_0, 3'b010, 2'b01, 2'b00, 5'b00000));
        step(6'b000000, 6'b001000);
        check("jr",     w(9'b0_0_0_0_0_0_0_1_0, 3'b000, 2'b00, 2'b10, 5'b00000));
        step(6'b000000, 6'b001001);
        check("jalr",   w(9'b1_0_0_0_0_0_0_1_1, 3'b000, 2'b01, 2'b10, 5'b00000));
        // I-types with a funct field that would mean JR for R-type
        step(6'b001000, 6'b001000);
        check("addi",   w(9'b1_1_0_0_0_0_0_0_0, 3'b000, 2'b00, 2'b00, 5'b00000));
        step(6'b001100, 6'b001001);
        check("andi",   w(9'b1_1_0_0_0_0_0_0_0, 3'b011, 2'b00, 2'b00, 5'b00000));
        step(6'b001101, 6'b111111);
        check("ori",    w(9'b1_1_0_0_0_0_0_0_0, 3'b100, 2'b00, 2'b00, 5'b00000));
        step(6'b001110, 6'b000000);
        check("xori",   w(9'b1_1_0_0_0_0_0_0_0, 3'b101, 2'b00, 2'b00, 5'b00000));
        step(6'b001010, 6'b000000);
        check("slti",   w(9'b1_1_0_0_0_0_0_0_0, 3'b111, 2'b00, 2'b00, 5'b00000));
        step(6'b001111, 6'b000000);
        check("lui",    w(9'b1_1_0_0_0_0_0_0_0, 3'b110, 2'b00, 2'b00, 5'b00000));
        step(6'b000100, 6'b000000);
        check("beq",    w(9'b0_0_0_0_0_1_0_0_0, 3'b001, 2'b00, 2'b00, 5'b00000));
        step(6'b000101, 6'b000000);
        check("bne",    w(9'b0_0_0_0_0_0_1_0_0, 3'b001, 2'b00, 2'b00, 5'b00000));
        step(6'b000010, 6'b000000);
        check("j",      w(9'b0_0_0_0_0_0_0_1_0, 3'b000, 2'b00, 2'b01, 5'b00000));
        step(6'b000011, 6'b000000);
        check("jal",    w(9'b1_0_0_0_0_0_0_1_1, 3'b000, 2'b10, 2'b01, 5'b00000));
        step(6'b100000, 6'b000000);
        check("lb",     w(9'b1_1_0_1_1_0_0_0_0, 3'b000, 2'b00, 2'b00, 5'b00001));
        step(6'b100001, 6'b000000);
        check("lh",     w(9'b1_1_0_1_1_0_0_0_0, 3'b000, 2'b00, 2'b00, 5'b00010));
        step(6'b100011, 6'b000000);
        check("lw",     w(9'b1_1_0_1_1_0_0_0_0, 3'b000, 2'b00, 2'b00, 5'b00100));
        step(6'b100100, 6'b000000);
        check("lbu",    w(9'b1_1_0_1_1_0_0_0_0, 3'b000, 2'b00, 2'b00, 5'b01001));
        step(6'b100101, 6'b000000);
        check("lhu",    w(9'b1_1_0_1_1_0_0_0_0, 3'b000, 2'b00, 2'b00, 5'b01010));
        step(6'b100111, 6'b000000);
        check("lwu",    w(9'b1_1_0_1_1_0_0_0_0, 3'b000, 2'b00, 2'b00, 5'b01100));
        step(6'b101000, 6'b000000);
        check("sb",     w(9'b0_1_1_0_0_0_0_0_0, 3'b000, 2'b00, 2'b00, 5'b10001));
        step(6'b101001, 6'b000000);
        check("sh",     w(9'b0_1_1_0_0_0_0_0_0, 3'b000, 2'b00, 2'b00, 5'b10010));
        step(6'b000001, 6'b000000);
        check("nop_01", '0);
        step(6'b101011, 6'b000000);
        check("sw",     w(9'b0_1_1_0_0_0_0_0_0, 3'b000, 2'b00, 2'b00, 5'b10100));

        // Mid-stream reset with LW applied: clears without a clock edge
        opcode  = 6'b100011;
        i_funct = 6'b000000;
        #2;
        i_reset_n = 1'b0;
        #1;
        check("rst_async", '0);
        @(posedge i_clk);
        #1;
        check("rst_held", '0);
        #2;
        i_reset_n = 1'b1;
        #1;
        check("rst_release", '0);
        @(posedge i_clk);
        #1;
        check("lw_after_rst", w(9'b1_1_0_1_1_0_0_0_0, 3'b000, 2'b00, 2'b00, 5'b00100));

`ifdef CONTROLLER_PIPE_FLUSH_EN
        i_flush = 1'b1;
        step(6'b000011, 6'b000000);
        check("flush", '0);
        i_flush = 1'b0;
        step(6'b000011, 6'b000000);
        check("after_flush", w(9'b1_0_0_0_0_0_0_1_1, 3'b000, 2'b10, 2'b01, 5'b00000));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
